// File: rtl/conway_sequencer.sv
// Generation sequencer for the Game of Life cell array.
// Turns one-cycle user commands into board clear/load/step strobes and paces
// free-running generations with a programmable divider and generation limit.
module conway_sequencer #(
    parameter int GEN_W = 16,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_clear,
    input  logic             cmd_load,
    input  logic             cmd_run,
    input  logic             cmd_pause,
    input  logic             cmd_step,
    input  logic [DIV_W-1:0] period,
    input  logic [GEN_W-1:0] gen_limit,
    output logic             board_clr,
    output logic             board_load,
    output logic             board_step,
    output logic [GEN_W-1:0] gen_count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PAUSED = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] div, div_n;
    logic [GEN_W-1:0] gen_n;
    logic             clr_n, load_n, step_n;

    logic [DIV_W-1:0] last_div;   // terminal divider value, eff_period-1
    logic             term;       // divider reached terminal count
    logic             over;       // limit already reached without a step
    logic [GEN_W-1:0] gen_inc;    // saturating gen_count+1
    logic             hit;        // a step now would land on the limit

    // Pacing and limit terms shared by the next-state logic
    always_comb begin
        last_div = (period == '0) ? '0 : period - 1'b1;
        term     = (div >= last_div);
        over     = (gen_limit != '0) && (gen_count >= gen_limit);
        gen_inc  = (&gen_count) ? gen_count : gen_count + 1'b1;
        hit      = (gen_limit != '0) && (gen_inc == gen_limit);
    end

    // Next state, divider, counter and strobes; command priority clear > load > pause > run > step
    always_comb begin
        state_n = state;
        div_n   = div;
        gen_n   = gen_count;
        clr_n   = 1'b0;
        load_n  = 1'b0;
        step_n  = 1'b0;
        if (cmd_clear) begin
            state_n = IDLE;
            clr_n   = 1'b1;
            gen_n   = '0;
            div_n   = '0;
        end else if (cmd_load) begin
            state_n = PAUSED;
            load_n  = 1'b1;
            gen_n   = '0;
            div_n   = '0;
        end else begin
            unique case (state)
                PAUSED: begin
                    if (over) begin
                        state_n = DONE;
                    end else if (cmd_pause) begin
                        state_n = PAUSED;
                    end else if (cmd_run) begin
                        state_n = RUN;
                        div_n   = '0;
                    end else if (cmd_step) begin
                        step_n = 1'b1;
                        gen_n  = gen_inc;
                        if (hit) state_n = DONE;
                    end
                end
                RUN: begin
                    if (over) begin
                        state_n = DONE;
                    end else if (cmd_pause) begin
                        // divider is left frozen; the next run restarts it
                        state_n = PAUSED;
                    end else if (term) begin
                        step_n = 1'b1;
                        gen_n  = gen_inc;
                        div_n  = '0;
                        if (hit) state_n = DONE;
                    end else begin
                        div_n = div + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE ignore run, pause and step
                end
            endcase
        end
    end

    // Registered state and outputs so every strobe is a clean one-cycle pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            div        <= '0;
            gen_count  <= '0;
            board_clr  <= 1'b0;
            board_load <= 1'b0;
            board_step <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            div        <= div_n;
            gen_count  <= gen_n;
            board_clr  <= clr_n;
            board_load <= load_n;
            board_step <= step_n;
            busy       <= (state_n == RUN);
            done       <= (state_n == DONE);
        end
    end

endmodule
